// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of the 4:1 bit mux select.
// Four requesters share one output bit; the granted requester's input is
// routed to out_o until it drops its request.
// Optional feature macro: MUX_ARB_HOLD_LIMIT_EN adds a hold counter and the
// MAX_HOLD parameter so a long-running owner is preempted when others wait.
//
// state | meaning
// IDLE  | no grant, gnt_o = 0000, busy_o = 0, s_o holds its last value
// GRANT | one-hot gnt_o, s_o = owner index, busy_o = 1
module mux_rr_arbiter
`ifdef MUX_ARB_HOLD_LIMIT_EN
#(
    parameter int unsigned MAX_HOLD = 8
)
`endif
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] req_i,
    input  logic [3:0] in_i,
    output logic [3:0] gnt_o,
    output logic [1:0] s_o,
    output logic       busy_o,
    output logic       out_o
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] s_q, s_d;
    logic [1:0] ptr_q, ptr_d;
    logic       busy_q, busy_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    logic [7:0] hold_q, hold_d;
`endif

    // Bit [2] = a requester was found, bits [1:0] = its index. The scan runs
    // from the far end back so the index closest to start is written last.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [3:0] others;
    logic [2:0] pick_idle;
    logic [2:0] pick_next;
    logic       take;
    logic [1:0] take_idx;

    // The current owner is masked out so the next-owner search never re-picks it.
    assign others    = req_i & ~(4'b0001 << s_q);
    assign pick_idle = rr_pick(req_i, ptr_q);
    assign pick_next = rr_pick(others, s_q + 2'd1);

    // Next-state logic: decide whether a new owner takes the mux, or whether we go idle.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        s_d      = s_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
        take     = 1'b0;
        take_idx = 2'd0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
        hold_d   = hold_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_idle[2]) begin
                    take     = 1'b1;
                    take_idx = pick_idle[1:0];
                end
            end
            GRANT: begin
                if (!req_i[s_q]) begin
                    if (pick_next[2]) begin
                        take     = 1'b1;
                        take_idx = pick_next[1:0];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                    end
                end
`ifdef MUX_ARB_HOLD_LIMIT_EN
                // Counter saturates at MAX_HOLD, so >= keeps preemption armed
                // once the owner has overstayed with nobody else waiting.
                else if ((hold_q >= 8'(MAX_HOLD - 1)) && pick_next[2]) begin
                    take     = 1'b1;
                    take_idx = pick_next[1:0];
                end else if (hold_q != 8'(MAX_HOLD)) begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (take) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << take_idx;
            s_d     = take_idx;
            ptr_d   = take_idx + 2'd1;
            busy_d  = 1'b1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_d  = 8'd0;
`endif
        end
    end

    // State and output registers; reset clears everything so out_o drops at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            s_q     <= 2'd0;
            ptr_q   <= 2'd0;
            busy_q  <= 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign gnt_o  = gnt_q;
    assign s_o    = s_q;
    assign busy_o = busy_q;
    assign out_o  = busy_q & in_i[s_q];

endmodule
